mem_stage: RTL and testbench

Pipeline memory-access stage between the EX/MEM buffer and `mem_wb_buffer`. It passes ALU and HI/LO results through. For load/store instructions it runs a request/acknowledge transaction on the data bus. It stalls the pipeline until the transaction completes, then presents sign- or zero-extended load data to `mem_wb_buffer` as a register write.

---
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU/HI/LO results through and runs a load/store
// request/ack bus transaction. Optional MEM_ALIGN_CHECK_EN aborts misaligned accesses.
module mem_stage #(
  parameter int BUS_TIMEOUT = 255,
  parameter int REGS_ADDR_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ex_write_enable,
  input  logic [REGS_ADDR_W-1:0] ex_write_addr,
  input  logic [31:0]            ex_write_data,
  input  logic                   ex_write_hilo_enable,
  input  logic [31:0]            ex_write_hi_data,
  input  logic [31:0]            ex_write_lo_data,
  input  logic [3:0]             ex_mem_op,
  input  logic [31:0]            ex_mem_addr,
  input  logic [31:0]            ex_mem_store_data,
  output logic                   mem_write_enable,
  output logic [REGS_ADDR_W-1:0] mem_write_addr,
  output logic [31:0]            mem_write_data,
  output logic                   mem_write_hilo_enable,
  output logic [31:0]            mem_write_hi_data,
  output logic [31:0]            mem_write_lo_data,
  output logic                   stall_request,
  output logic                   bus_request,
  output logic                   bus_write,
  output logic [31:0]            bus_addr,
  output logic [3:0]             bus_byte_sel,
  output logic [31:0]            bus_wdata,
  input  logic [31:0]            bus_rdata,
  input  logic                   bus_ack,
  output logic                   bus_error
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;

  logic        is_load, is_store, is_mem, is_half, is_word, misalign;
  logic [1:0]  lane_lo;
  logic [3:0]  sel;
  logic [31:0] wdata, shifted, ld_data;

  always_comb begin
    is_load  = ex_mem_op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_store = ex_mem_op inside {OP_SB, OP_SH, OP_SW};
    is_mem   = is_load | is_store;
    is_half  = ex_mem_op inside {OP_LH, OP_LHU, OP_SH};
    is_word  = ex_mem_op inside {OP_LW, OP_SW};
`ifdef MEM_ALIGN_CHECK_EN
    misalign = (is_half & ex_mem_addr[0]) | (is_word & (|ex_mem_addr[1:0]));
`else
    misalign = 1'b0;
`endif
  end

  // Lane decode; halfword/word accesses ignore the low address bits they cannot use.
  always_comb begin
    lane_lo = 2'd0;
    sel     = 4'b1111;
    wdata   = ex_mem_store_data;
    if (is_half) begin
      lane_lo = {ex_mem_addr[1], 1'b0};
      sel     = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata   = {2{ex_mem_store_data[15:0]}};
    end else if (!is_word) begin
      lane_lo = ex_mem_addr[1:0];
      sel     = 4'b0001 << ex_mem_addr[1:0];
      wdata   = {4{ex_mem_store_data[7:0]}};
    end
  end

  always_comb begin
    shifted = rdata_q >> {lane_lo, 3'b000};
    case (ex_mem_op)
      OP_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  ld_data = {24'd0, shifted[7:0]};
      OP_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    rdata_d               = rdata_q;
    cnt_d                 = cnt_q;
    abort_d               = abort_q;
    mem_write_enable      = ex_write_enable;
    mem_write_addr        = ex_write_addr;
    mem_write_data        = ex_write_data;
    mem_write_hilo_enable = ex_write_hilo_enable;
    mem_write_hi_data     = ex_write_hi_data;
    mem_write_lo_data     = ex_write_lo_data;
    stall_request         = 1'b0;
    bus_request           = 1'b0;
    bus_write             = 1'b0;
    bus_addr              = 32'd0;
    bus_byte_sel          = 4'd0;
    bus_wdata             = 32'd0;
    bus_error             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          stall_request         = 1'b1;
          mem_write_enable      = 1'b0;
          mem_write_hilo_enable = 1'b0;
          cnt_d                 = 8'd0;
          abort_d               = misalign;
          state_d               = misalign ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_request         = 1'b1;
        mem_write_enable      = 1'b0;
        mem_write_hilo_enable = 1'b0;
        bus_request           = 1'b1;
        bus_write             = is_store;
        bus_addr              = {ex_mem_addr[31:2], 2'b00};
        bus_byte_sel          = sel;
        bus_wdata             = wdata;
        cnt_d                 = cnt_q + 8'd1;
        if (bus_ack) begin
          rdata_d = bus_rdata;
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          abort_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        if (abort_q) begin
          mem_write_enable = 1'b0;
          bus_error        = 1'b1;
        end else if (is_load) begin
          mem_write_data = ld_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs hold their reset values for as long as reset is asserted.
    if (!reset) begin
      mem_write_enable      = 1'b0;
      mem_write_addr        = '0;
      mem_write_data        = 32'd0;
      mem_write_hilo_enable = 1'b0;
      mem_write_hi_data     = 32'd0;
      mem_write_lo_data     = 32'd0;
      stall_request         = 1'b0;
      bus_request           = 1'b0;
      bus_write             = 1'b0;
      bus_addr              = 32'd0;
      bus_byte_sel          = 4'd0;
      bus_wdata             = 32'd0;
      bus_error             = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a per-transaction reference model predicts every cycle.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clock = 1'b0, reset = 1'b0;
  logic        ex_write_enable = 0, ex_write_hilo_enable = 0;
  logic [4:0]  ex_write_addr = 0;
  logic [31:0] ex_write_data = 0, ex_write_hi_data = 0, ex_write_lo_data = 0;
  logic [3:0]  ex_mem_op = 0;
  logic [31:0] ex_mem_addr = 0, ex_mem_store_data = 0, bus_rdata = 0;
  logic        bus_ack = 0;
  logic        mem_write_enable, mem_write_hilo_enable, stall_request;
  logic        bus_request, bus_write, bus_error;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data, mem_write_hi_data, mem_write_lo_data, bus_addr, bus_wdata;
  logic [3:0]  bus_byte_sel;

  always #5 clock = ~clock;

  mem_stage #(.BUS_TIMEOUT(TO), .REGS_ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
    .ex_write_data(ex_write_data), .ex_write_hilo_enable(ex_write_hilo_enable),
    .ex_write_hi_data(ex_write_hi_data), .ex_write_lo_data(ex_write_lo_data),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_store_data(ex_mem_store_data),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_hilo_enable(mem_write_hilo_enable),
    .mem_write_hi_data(mem_write_hi_data), .mem_write_lo_data(mem_write_lo_data),
    .stall_request(stall_request), .bus_request(bus_request), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_byte_sel(bus_byte_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_error(bus_error)
  );

  int n_chk = 0, n_fail = 0;
  int stall_cnt;
  logic [31:0] done_data, w_addr, w_wdata;
  logic [3:0]  w_sel;
  logic        done_err, done_we, w_write;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [3:0] op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  // One instruction, starting just after the edge that enters IDLE. ack_at = WAIT cycle of the ack (0: never).
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] alu, input logic [31:0] rdat, input int ack_at);
    int sz, lo, k;
    logic ld, st, mis, aborted, fin;
    logic [31:0] rd, bm, wexp, ext, lmask;
    logic [3:0] sel;
    sz  = acc_size(op);
    ld  = op inside {[1:5]};
    st  = op inside {[6:8]};
    lo  = (sz == 4) ? 0 : (sz == 2) ? int'(addr[1]) * 2 : int'(addr[1:0]);
    sel = 4'(((1 << sz) - 1) << lo);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 0);
`endif
    bm = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) bm |= 32'hFF << (8 * i);
    wexp = 32'((64'(sdata) & ((64'd1 << (8 * sz)) - 1)) << (8 * lo));
    ex_mem_op = op; ex_mem_addr = addr; ex_mem_store_data = sdata; ex_write_data = alu;
    ex_write_enable = 1'($urandom); ex_write_hilo_enable = 1'($urandom);
    ex_write_addr = 5'($urandom); ex_write_hi_data = $urandom; ex_write_lo_data = $urandom;
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    stall_cnt = 0;
    @(negedge clock);
    check("hi", mem_write_hi_data, ex_write_hi_data);
    check("lo", mem_write_lo_data, ex_write_lo_data);
    check("waddr", mem_write_addr, ex_write_addr);
    check("idle_breq", bus_request, 0);
    check("idle_berr", bus_error, 0);
    if (!(ld || st)) begin
      check("pt_we", mem_write_enable, ex_write_enable);
      check("pt_data", mem_write_data, alu);
      check("pt_hilo", mem_write_hilo_enable, ex_write_hilo_enable);
      check("pt_stall", stall_request, 0);
      done_data = mem_write_data;
      @(posedge clock); #1;
      return;
    end
    check("idle_stall", stall_request, 1);
    check("idle_we", mem_write_enable, 0);
    check("idle_hilo", mem_write_hilo_enable, 0);
    stall_cnt += int'(stall_request);
    @(posedge clock); #1;
    aborted = mis;
    rd = 0;
    if (!mis) begin
      k = 1; fin = 0;
      while (!fin) begin
        bus_ack = (k == ack_at);
        bus_rdata = (k == ack_at) ? rdat : $urandom;
        @(negedge clock);
        check("w_breq", bus_request, 1);
        check("w_stall", stall_request, 1);
        check("w_we", mem_write_enable, 0);
        check("w_hilo", mem_write_hilo_enable, 0);
        check("w_addr", bus_addr, {addr[31:2], 2'b00});
        check("w_write", bus_write, st);
        check("w_sel", bus_byte_sel, sel);
        if (st) check("w_wdata", bus_wdata & bm, wexp);
        check("w_berr", bus_error, 0);
        stall_cnt += int'(stall_request);
        w_addr = bus_addr; w_sel = bus_byte_sel; w_wdata = bus_wdata; w_write = bus_write;
        if (bus_ack) begin rd = rdat; fin = 1; end
        else if (k == TO) begin aborted = 1; fin = 1; end
        else begin k++; @(posedge clock); #1; end
      end
      @(posedge clock); #1;
    end
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    lmask = (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * sz)) - 1);
    ext = (rd >> (8 * lo)) & lmask;
    if ((op == 1 || op == 3) && ext[8 * sz - 1]) ext |= ~lmask;
    @(negedge clock);
    check("d_stall", stall_request, 0);
    check("d_breq", bus_request, 0);
    check("d_berr", bus_error, aborted);
    check("d_we", mem_write_enable, aborted ? 1'b0 : ex_write_enable);
    check("d_hilo", mem_write_hilo_enable, ex_write_hilo_enable);
    if (!aborted) check("d_data", mem_write_data, ld ? ext : alu);
    done_data = mem_write_data; done_err = bus_error; done_we = mem_write_enable;
    @(posedge clock); #1;
    bus_ack = 0;
  endtask

  initial begin
    reset = 0;
    ex_mem_op = 4'd5; ex_write_data = 32'hDEAD_BEEF; ex_write_enable = 1;
    ex_write_hilo_enable = 1; ex_write_hi_data = 32'h1111; ex_write_lo_data = 32'h2222;
    bus_ack = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_we", mem_write_enable, 0);
    check("rst_hilo", mem_write_hilo_enable, 0);
    check("rst_data", mem_write_data, 0);
    check("rst_hi", mem_write_hi_data, 0);
    check("rst_stall", stall_request, 0);
    check("rst_breq", bus_request, 0);
    check("rst_berr", bus_error, 0);
    @(posedge clock); #1;
    reset = 1; ex_mem_op = 0; bus_ack = 0;

    run_op(4'd0, 32'd5, 32'd0, 32'h1234_5678, 32'd0, 1);
    check("alu_data", done_data, 32'h1234_5678);
    check("alu_stalls", stall_cnt, 0);

    run_op(4'd1, 32'h103, 32'd0, 32'h0, 32'h80AA_BBCC, 1);
    check("lb_addr", w_addr, 32'h100);
    check("lb_sel", w_sel, 4'b1000);
    check("lb_stalls", stall_cnt, 2);
    check("lb_data", done_data, 32'hFFFF_FF80);
    run_op(4'd2, 32'h103, 32'd0, 32'h0, 32'h80AA_BBCC, 1);
    check("lbu_data", done_data, 32'h0000_0080);

    run_op(4'd7, 32'h202, 32'h0000_BEEF, 32'h0, 32'h0, 3);
    check("sh_write", w_write, 1);
    check("sh_sel", w_sel, 4'b1100);
    check("sh_wdata_hi", w_wdata[31:16], 16'hBEEF);
    check("sh_stalls", stall_cnt, 4);

    run_op(4'd5, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    check("to_stalls", stall_cnt, TO + 1);
    check("to_berr", done_err, 1);
    check("to_we", done_we, 0);
    run_op(4'd0, 32'h0, 32'h0, 32'h55, 32'h0, 0);

    // Reset during the second WAIT cycle; a later ack must not complete anything.
    ex_mem_op = 4'd5; ex_mem_addr = 32'h400; bus_ack = 0;
    @(posedge clock); #1;
    @(negedge clock);
    check("rw_breq1", bus_request, 1);
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    check("rw_breq", bus_request, 0);
    check("rw_stall", stall_request, 0);
    check("rw_we", mem_write_enable, 0);
    check("rw_data", mem_write_data, 0);
    check("rw_berr", bus_error, 0);
    @(posedge clock); #1;
    reset = 1; ex_mem_op = 0;
    @(negedge clock);
    check("rw_idle_stall", stall_request, 0);
    @(posedge clock); #1;
    bus_ack = 0;
    @(negedge clock);
    check("rw_idle_breq", bus_request, 0);
    check("rw_idle_berr", bus_error, 0);
    @(posedge clock); #1;

    run_op(4'd5, 32'h302, 32'h0, 32'h0, 32'h1357_9BDF, 1);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_stalls", stall_cnt, 1);
    check("mis_berr", done_err, 1);
    check("mis_we", done_we, 0);
`else
    check("mis_stalls", stall_cnt, 2);
    check("mis_data", done_data, 32'h1357_9BDF);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(4'($urandom_range(0, 15)), a, $urandom, $urandom, $urandom, $urandom_range(0, TO + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
